// File: rtl/aud_ctrl_pkg.sv
// Shared widths, FSM state encoding and small helpers for the audio write arbiter.
package aud_ctrl_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 7;
    localparam int N_REQ  = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_DATA = 2'd1,
        RESP      = 2'd2,
        DONE      = 2'd3
    } state_t;

    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/aud_wr_arbiter_if.sv
// Write-address / write-data / write-response bus between the arbiter and the memory side.
interface aud_wr_arbiter_if;
    import aud_ctrl_pkg::*;

    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic              WVALID;
    logic              WREADY;
    logic              BVALID;
    logic              BREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WVALID, BREADY,
        input  AWREADY, WREADY, BVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WVALID, BREADY,
        output AWREADY, WREADY, BVALID
    );

endinterface

// File: rtl/aud_wr_arbiter_rr.sv
// Combinational round-robin picker: lowest requesting index at or after ptr, wrapping.
module rr_arbiter
    import aud_ctrl_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic             gnt_valid,
    output logic [1:0]       gnt_idx
);

    logic [N_REQ-1:0] rot_s;
    logic [1:0]       off_s;

    // Rotate so the pointer position lands on bit 0, then take the lowest set bit.
    always_comb begin
        rot_s = N_REQ'({req, req} >> ptr);
        off_s = 2'd0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                off_s = 2'(k);
            end else begin
                off_s = off_s;
            end
        end
        gnt_valid = |rot_s;
        gnt_idx   = ptr + off_s;
    end

endmodule

// File: rtl/aud_wr_arbiter.sv
// Arbitrates four requesters onto one write bus; one transaction at a time with a
// response timeout that aborts and reports err to the owning requester.
module aud_wr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                                clk,
    input  logic                                ARESET,
    input  logic [N_REQ-1:0]                    req,
    input  logic [N_REQ*aud_ctrl_pkg::ADDR_W-1:0] req_addr,
    input  logic [N_REQ*aud_ctrl_pkg::DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]                    ack,
    output logic [N_REQ-1:0]                    err,
    output logic                                busy,
    aud_wr_arbiter_if.master                    bus
);
    import aud_ctrl_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_r;
    logic [1:0]        g_r, ptr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              aw_done_r, w_done_r;
    logic              awvalid_r, wvalid_r, bready_r, busy_r;
    logic [ADDR_W-1:0] awaddr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [N_REQ-1:0]  ack_r, err_r;

    logic              gnt_valid_s;
    logic [1:0]        gnt_idx_s;
    logic              aw_hs_s, w_hs_s, aw_fin_s, w_fin_s;

    rr_arbiter u_rr (
        .req       (req),
        .ptr       (ptr_r),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    assign aw_hs_s  = awvalid_r & bus.AWREADY;
    assign w_hs_s   = wvalid_r & bus.WREADY;
    assign aw_fin_s = aw_done_r | aw_hs_s;
    assign w_fin_s  = w_done_r | w_hs_s;

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (ARESET) begin
            state_r   <= IDLE;
            g_r       <= 2'd0;
            ptr_r     <= 2'd0;
            cnt_r     <= {CNT_W{1'b0}};
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            busy_r    <= 1'b0;
            awaddr_r  <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            ack_r     <= {N_REQ{1'b0}};
            err_r     <= {N_REQ{1'b0}};
        end else begin
            ack_r <= {N_REQ{1'b0}};
            err_r <= {N_REQ{1'b0}};
            case (state_r)
                IDLE: begin
                    if (gnt_valid_s) begin
                        g_r       <= gnt_idx_s;
                        awaddr_r  <= req_addr[ADDR_W*gnt_idx_s +: ADDR_W];
                        wdata_r   <= req_data[DATA_W*gnt_idx_s +: DATA_W];
                        awvalid_r <= 1'b1;
                        wvalid_r  <= 1'b1;
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        cnt_r     <= {CNT_W{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= ADDR_DATA;
                    end
                end
                ADDR_DATA: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        awvalid_r <= 1'b0;
                        wvalid_r  <= 1'b0;
                        bready_r  <= 1'b0;
                        err_r     <= onehot4(g_r);
                        ptr_r     <= g_r + 2'd1;
                        state_r   <= DONE;
                    end else begin
                        // Each channel drops its VALID independently once accepted.
                        awvalid_r <= awvalid_r & ~bus.AWREADY;
                        wvalid_r  <= wvalid_r & ~bus.WREADY;
                        aw_done_r <= aw_fin_s;
                        w_done_r  <= w_fin_s;
                        if (aw_fin_s && w_fin_s) begin
                            bready_r <= 1'b1;
                            state_r  <= RESP;
                        end
                    end
                end
                RESP: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    // A response on the last budget cycle still counts as completion.
                    if (bus.BVALID) begin
                        bready_r <= 1'b0;
                        ack_r    <= onehot4(g_r);
                        ptr_r    <= g_r + 2'd1;
                        state_r  <= DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        bready_r <= 1'b0;
                        err_r    <= onehot4(g_r);
                        ptr_r    <= g_r + 2'd1;
                        state_r  <= DONE;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    bready_r  <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign bus.AWADDR  = awaddr_r;
    assign bus.AWVALID = awvalid_r;
    assign bus.WDATA   = wdata_r;
    assign bus.WVALID  = wvalid_r;
    assign bus.BREADY  = bready_r;
    assign ack         = ack_r;
    assign err         = err_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_aud_wr_arbiter.sv
// Directed bench for aud_wr_arbiter: single write, fairness, skewed handshake,
// timeout, completion/timeout tie and reset in the middle of a response.
module tb_aud_wr_arbiter;

    logic        clk;
    logic        ARESET;
    logic [3:0]  req;
    logic [15:0] req_addr;
    logic [27:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic        busy;
    int          n_tests;
    int          n_fail;
    logic [3:0]  exp_ack;

    aud_wr_arbiter_if bus ();

    aud_wr_arbiter #(.N_REQ(4), .TIMEOUT(64)) dut (
        .clk      (clk),
        .ARESET   (ARESET),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        tick();
        tick();
        ARESET = 1'b0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        ARESET      = 1'b0;
        req         = 4'b0000;
        // addr: r0=3 r1=5 r2=9 r3=C ; data: r0=11 r1=2A r2=33 r3=55
        req_addr    = {4'hC, 4'h9, 4'h5, 4'h3};
        req_data    = {7'h55, 7'h33, 7'h2A, 7'h11};
        bus.AWREADY = 1'b1;
        bus.WREADY  = 1'b1;
        bus.BVALID  = 1'b1;

        do_reset();
        chk("rst_awvalid", 32'(bus.AWVALID), 32'd0);
        chk("rst_wvalid",  32'(bus.WVALID),  32'd0);
        chk("rst_bready",  32'(bus.BREADY),  32'd0);
        chk("rst_awaddr",  32'(bus.AWADDR),  32'd0);
        chk("rst_wdata",   32'(bus.WDATA),   32'd0);
        chk("rst_ack",     32'(ack),         32'd0);
        chk("rst_err",     32'(err),         32'd0);
        chk("rst_busy",    32'(busy),        32'd0);

        // Single write from requester 1, everything ready, BVALID tied high.
        req = 4'b0010;
        tick();
        chk("single_awvalid", 32'(bus.AWVALID), 32'd1);
        chk("single_wvalid",  32'(bus.WVALID),  32'd1);
        chk("single_awaddr",  32'(bus.AWADDR),  32'h5);
        chk("single_wdata",   32'(bus.WDATA),   32'h2A);
        chk("single_bready0", 32'(bus.BREADY),  32'd0);
        chk("single_busy",    32'(busy),        32'd1);
        tick();
        chk("single_awdrop",  32'(bus.AWVALID), 32'd0);
        chk("single_wdrop",   32'(bus.WVALID),  32'd0);
        chk("single_bready",  32'(bus.BREADY),  32'd1);
        chk("single_noack",   32'(ack),         32'd0);
        tick();
        chk("single_ack",     32'(ack),         32'h2);
        chk("single_noerr",   32'(err),         32'd0);
        chk("single_bready_d",32'(bus.BREADY),  32'd0);
        req = 4'b0000;
        tick();
        chk("single_ackpulse",32'(ack),         32'd0);
        chk("single_idle",    32'(busy),        32'd0);

        // Fairness: all four requesting from reset -> acks 0,1,2,3.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                if (ack !== 4'b0000) break;
            end
            exp_ack = 4'b0001 << k;
            chk("fair_ack", 32'(ack), 32'(exp_ack));
            chk("fair_err", 32'(err), 32'd0);
        end
        req = 4'b0000;
        tick();

        // Skewed handshake: AW stalled three cycles, W accepted at once.
        bus.AWREADY = 1'b0;
        req = 4'b1000;
        tick();
        chk("skew_awvalid1", 32'(bus.AWVALID), 32'd1);
        chk("skew_wvalid1",  32'(bus.WVALID),  32'd1);
        chk("skew_awaddr",   32'(bus.AWADDR),  32'hC);
        chk("skew_wdata",    32'(bus.WDATA),   32'h55);
        tick();
        chk("skew_wdrop",    32'(bus.WVALID),  32'd0);
        chk("skew_awvalid2", 32'(bus.AWVALID), 32'd1);
        tick();
        chk("skew_awvalid3", 32'(bus.AWVALID), 32'd1);
        chk("skew_nobready", 32'(bus.BREADY),  32'd0);
        tick();
        chk("skew_awvalid4", 32'(bus.AWVALID), 32'd1);
        chk("skew_awstable", 32'(bus.AWADDR),  32'hC);
        bus.AWREADY = 1'b1;
        tick();
        chk("skew_awdrop",   32'(bus.AWVALID), 32'd0);
        chk("skew_bready",   32'(bus.BREADY),  32'd1);
        tick();
        chk("skew_ack",      32'(ack),         32'h8);
        req = 4'b0000;
        tick();

        // Timeout: no response, err 64 cycles after ADDR_DATA entry.
        bus.BVALID = 1'b0;
        req = 4'b0001;
        tick();
        chk("to_awvalid", 32'(bus.AWVALID), 32'd1);
        repeat (63) tick();
        chk("to_pre_err",    32'(err),         32'd0);
        chk("to_pre_bready", 32'(bus.BREADY),  32'd1);
        chk("to_pre_busy",   32'(busy),        32'd1);
        tick();
        chk("to_err",        32'(err),         32'h1);
        chk("to_noack",      32'(ack),         32'd0);
        chk("to_awvalid0",   32'(bus.AWVALID), 32'd0);
        chk("to_wvalid0",    32'(bus.WVALID),  32'd0);
        chk("to_bready0",    32'(bus.BREADY),  32'd0);
        req = 4'b0000;
        tick();
        chk("to_errpulse",   32'(err),         32'd0);
        chk("to_idle",       32'(busy),        32'd0);
        // Pointer moved past requester 0, so requester 1 wins.
        bus.BVALID = 1'b1;
        req = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ack !== 4'b0000) break;
        end
        chk("to_ptr_adv", 32'(ack), 32'h2);
        req = 4'b0000;
        tick();

        // Response on the very last budget cycle: completion wins.
        bus.BVALID = 1'b0;
        req = 4'b0100;
        tick();
        repeat (63) tick();
        chk("tie_pre_bready", 32'(bus.BREADY), 32'd1);
        bus.BVALID = 1'b1;
        tick();
        chk("tie_ack",   32'(ack), 32'h4);
        chk("tie_noerr", 32'(err), 32'd0);
        req = 4'b0000;
        bus.BVALID = 1'b0;
        tick();

        // Reset in the middle of RESP.
        req = 4'b0010;
        tick();
        tick();
        chk("rr_bready", 32'(bus.BREADY), 32'd1);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        chk("rr_bready0",  32'(bus.BREADY),  32'd0);
        chk("rr_awvalid0", 32'(bus.AWVALID), 32'd0);
        chk("rr_awaddr0",  32'(bus.AWADDR),  32'd0);
        chk("rr_busy0",    32'(busy),        32'd0);
        chk("rr_ack0",     32'(ack),         32'd0);
        chk("rr_err0",     32'(err),         32'd0);
        req = 4'b0000;
        tick();
        chk("rr_noack", 32'(ack),  32'd0);
        chk("rr_noerr", 32'(err),  32'd0);
        chk("rr_idle",  32'(busy), 32'd0);
        bus.BVALID = 1'b1;
        req = 4'b0100;
        tick();
        chk("rr_awaddr", 32'(bus.AWADDR), 32'h9);
        chk("rr_wdata",  32'(bus.WDATA),  32'h33);
        tick();
        tick();
        chk("rr_ack", 32'(ack), 32'h4);
        req = 4'b0000;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
